debouncer_multi: RTL and testbench

- Parametrised multi-channel successor to the single-key debouncer. Each of CHANNELS raw key/switch inputs gets its own synchroniser, glitch filter and debounced state register.
- Produces a per-channel debounced level plus one-cycle press and release strobes.
- Sits between board pins and the UI/control logic; one instance replaces N single-key debouncers.

---
 rtl/debouncer_multi.sv | 123 ++++++++++++
 tb/tb_debouncer_multi.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/debouncer_multi.sv
// debouncer_multi: per-channel 2-flop synchroniser, glitch filter and
// debounced level with registered one-cycle press/release strobes.
// Optional auto-repeat of the press strobe: define DEBOUNCER_MULTI_AUTOREPEAT_EN.
module debouncer_multi #(
  parameter int unsigned CHANNELS            = 4,
  parameter int unsigned CLK_FREQ_MHZ        = 100,
  parameter int unsigned GLITCH_TIME_NS      = 70,
  parameter int unsigned KEY_ACTIVE_LOW      = 0,
  parameter int unsigned REPEAT_DELAY_TICKS  = 16,
  parameter int unsigned REPEAT_PERIOD_TICKS = 8
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic [CHANNELS-1:0] key_i,
  output logic [CHANNELS-1:0] key_state_o,
  output logic [CHANNELS-1:0] key_pressed_stb_o,
  output logic [CHANNELS-1:0] key_released_stb_o
);

  localparam int unsigned WAIT_RAW   = (GLITCH_TIME_NS * CLK_FREQ_MHZ) / 1000;
  localparam int unsigned WAIT_TICKS = (WAIT_RAW < 1) ? 1 : WAIT_RAW;
  localparam int unsigned CNT_W      = $clog2(WAIT_TICKS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_TICKS - 1);
  localparam logic ACT_LO   = (KEY_ACTIVE_LOW != 0);
  localparam logic RAW_IDLE = ACT_LO;

`ifdef DEBOUNCER_MULTI_AUTOREPEAT_EN
  localparam int unsigned REP_MAX = (REPEAT_DELAY_TICKS > REPEAT_PERIOD_TICKS) ?
                                    REPEAT_DELAY_TICKS : REPEAT_PERIOD_TICKS;
  localparam int unsigned RCNT_W  = $clog2(REP_MAX + 1);
  localparam logic [RCNT_W-1:0] REP_FIRST_LAST = RCNT_W'(REPEAT_DELAY_TICKS - 1);
  localparam logic [RCNT_W-1:0] REP_NEXT_LAST  = RCNT_W'(REPEAT_PERIOD_TICKS - 1);

  typedef enum logic {REP_FIRST, REP_NEXT} rep_phase_e;
`endif

  if (CHANNELS < 1 || REPEAT_DELAY_TICKS < 1 || REPEAT_PERIOD_TICKS < 1) begin : g_param_err
    $error("debouncer_multi: CHANNELS and repeat tick counts must be >= 1");
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic             s1;
    logic             s2;
    logic             lvl;
    logic             state;
    logic             accept;
    logic             rep_fire;
    logic             press_q;
    logic             rel_q;
    logic [CNT_W-1:0] cnt;

    // normalised level (1 = pressed) and filter saturation
    always_comb begin
      lvl    = s2 ^ ACT_LO;
      accept = (lvl != state) && (cnt == CNT_LAST);
    end

    // synchroniser, glitch filter, debounced state and strobes
    always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
        s1      <= RAW_IDLE;
        s2      <= RAW_IDLE;
        state   <= 1'b0;
        cnt     <= '0;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
      end else begin
        s1      <= key_i[i];
        s2      <= s1;
        press_q <= (accept & lvl) | rep_fire;
        rel_q   <= accept & ~lvl;
        if (accept) begin
          state <= lvl;
          cnt   <= '0;
        end else if (lvl == state) begin
          cnt <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end

`ifdef DEBOUNCER_MULTI_AUTOREPEAT_EN
    logic [RCNT_W-1:0] rcnt;
    logic [RCNT_W-1:0] rep_last;
    rep_phase_e        rep_phase;

    // repeat fires only while held and never on the edge a release is accepted
    always_comb begin
      rep_last = (rep_phase == REP_FIRST) ? REP_FIRST_LAST : REP_NEXT_LAST;
      rep_fire = state && !accept && (rcnt == rep_last);
    end

    // repeat timer: restarts on every accepted transition
    always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
        rcnt      <= '0;
        rep_phase <= REP_FIRST;
      end else if (accept) begin
        rcnt      <= '0;
        rep_phase <= REP_FIRST;
      end else if (state) begin
        if (rep_fire) begin
          rcnt      <= '0;
          rep_phase <= REP_NEXT;
        end else begin
          rcnt <= rcnt + RCNT_W'(1);
        end
      end
    end
`else
    // no auto-repeat in this build
    always_comb begin
      rep_fire = 1'b0;
    end
`endif

    assign key_state_o[i]        = state;
    assign key_pressed_stb_o[i]  = press_q;
    assign key_released_stb_o[i] = rel_q;
  end

endmodule

// File: tb/tb_debouncer_multi.sv
// Bench for debouncer_multi: a 4-channel active-high instance and a
// 1-channel active-low instance, checked every cycle against a history model.
module tb_debouncer_multi;

  localparam int W_RAW = (70 * 100) / 1000;
  localparam int W     = (W_RAW < 1) ? 1 : W_RAW;
  localparam int HL    = W + 2;
  localparam int NCH   = 5;   // 0..3 active-high DUT, 4 active-low DUT
`ifdef DEBOUNCER_MULTI_AUTOREPEAT_EN
  localparam int RD = 16;
  localparam int RP = 8;
`endif

  logic       clk;
  logic       rstn;
  logic [3:0] key_hi;
  logic [3:0] state_hi, press_hi, rel_hi;
  logic [0:0] key_lo;
  logic [0:0] state_lo, press_lo, rel_lo;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  // model: raw sample history per channel, index 0 = sampled at latest edge
  bit          hist    [NCH][HL];
  bit          m_state [NCH];
  bit          m_press [NCH];
  bit          m_rel   [NCH];
  int unsigned m_acc   [NCH];
  int unsigned edge_no;

  debouncer_multi dut_hi (
    .clk_i              (clk),
    .rstn_i             (rstn),
    .key_i              (key_hi),
    .key_state_o        (state_hi),
    .key_pressed_stb_o  (press_hi),
    .key_released_stb_o (rel_hi)
  );

  debouncer_multi #(
    .CHANNELS       (1),
    .KEY_ACTIVE_LOW (1)
  ) dut_lo (
    .clk_i              (clk),
    .rstn_i             (rstn),
    .key_i              (key_lo),
    .key_state_o        (state_lo),
    .key_pressed_stb_o  (press_lo),
    .key_released_stb_o (rel_lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit act_lo(input int ch);
    return (ch == 4);
  endfunction

  task automatic model_reset();
    for (int ch = 0; ch < NCH; ch++) begin
      for (int j = 0; j < HL; j++) hist[ch][j] = act_lo(ch);
      m_state[ch] = 1'b0;
      m_press[ch] = 1'b0;
      m_rel[ch]   = 1'b0;
      m_acc[ch]   = 0;
    end
  endtask

  // a level change is accepted once W consecutive synchronised samples
  // (raw delayed by two edges) all differ from the current debounced state
  task automatic model_edge();
    if (!rstn) begin
      model_reset();
      return;
    end
    edge_no++;
    for (int ch = 0; ch < NCH; ch++) begin
      bit raw;
      bit all_diff;
      raw = (ch < 4) ? key_hi[ch] : key_lo[0];
      for (int j = HL - 1; j >= 1; j--) hist[ch][j] = hist[ch][j-1];
      hist[ch][0] = raw;
      all_diff = 1'b1;
      for (int j = 2; j < HL; j++)
        if ((hist[ch][j] ^ act_lo(ch)) == m_state[ch]) all_diff = 1'b0;
      m_press[ch] = 1'b0;
      m_rel[ch]   = 1'b0;
      if (all_diff) begin
        m_state[ch] = ~m_state[ch];
        if (m_state[ch]) begin
          m_press[ch] = 1'b1;
          m_acc[ch]   = edge_no;
        end else begin
          m_rel[ch] = 1'b1;
        end
      end
`ifdef DEBOUNCER_MULTI_AUTOREPEAT_EN
      else if (m_state[ch]) begin
        int unsigned d;
        d = edge_no - m_acc[ch];
        if (d == RD || (d > RD && ((d - RD) % RP) == 0)) m_press[ch] = 1'b1;
      end
`endif
    end
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp_v);
    n_total++;
    assert (obs === exp_v) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp_v);
    n_total++;
    assert (obs === exp_v) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic check_all();
    logic [3:0] es, ep, er;
    es = '0; ep = '0; er = '0;
    for (int ch = 0; ch < 4; ch++) begin
      es[ch] = m_state[ch];
      ep[ch] = m_press[ch];
      er[ch] = m_rel[ch];
    end
    chk("state_hi", state_hi, es);
    chk("press_hi", press_hi, ep);
    chk("rel_hi",   rel_hi,   er);
    chk("excl_hi",  press_hi & rel_hi, 4'b0000);
    chk("state_lo", {3'b000, state_lo}, {3'b000, m_state[4]});
    chk("press_lo", {3'b000, press_lo}, {3'b000, m_press[4]});
    chk("rel_lo",   {3'b000, rel_lo},   {3'b000, m_rel[4]});
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  // ticks until the selected strobe is seen; t = tick index (1-based) or -1
  task automatic find_strobe(input int ch, input bit rel, input int maxt, output int t);
    bit s;
    t = -1;
    for (int k = 1; k <= maxt; k++) begin
      tick();
      if (ch < 4) s = rel ? rel_hi[ch] : press_hi[ch];
      else        s = rel ? rel_lo[0]  : press_lo[0];
      if (s) begin
        t = k;
        break;
      end
    end
  endtask

  initial begin
    int t, t0, t2, cnt_p, n_all;
    key_hi  = '0;
    key_lo  = 1'b1;
    rstn    = 1'b0;
    edge_no = 0;
    model_reset();

    // reset state
    repeat (3) tick();
    chk("reset_state", state_hi, 4'b0000);
    rstn = 1'b1;
    repeat (3) tick();

    // clean step on channel 0: press then release, 9 edges each
    key_hi[0] = 1'b1;
    find_strobe(0, 1'b0, 20, t);
    chk_int("ch0_press_latency", t, 9);
    repeat (6) tick();
    key_hi[0] = 1'b0;
    find_strobe(0, 1'b1, 20, t);
    chk_int("ch0_release_latency", t, 9);
    repeat (4) tick();

    // short pulses on channel 1 are rejected, a long hold is accepted once
    cnt_p = 0;
    repeat (5) begin
      key_hi[1] = 1'b1;
      repeat (6) begin tick(); if (press_hi[1] || rel_hi[1]) cnt_p++; end
      key_hi[1] = 1'b0;
      repeat (3) begin tick(); if (press_hi[1] || rel_hi[1]) cnt_p++; end
    end
    chk_int("glitch_no_strobe", cnt_p, 0);
    chk("glitch_state", {3'b000, state_hi[1]}, 4'b0000);
    key_hi[1] = 1'b1;
    repeat (12) begin tick(); if (press_hi[1]) cnt_p++; end
    chk_int("ch1_hold_one_press", cnt_p, 1);
    key_hi[1] = 1'b0;
    repeat (12) tick();

    // all channels together: one cycle of 4'b1111
    key_hi = 4'b1111;
    n_all = 0;
    repeat (14) begin tick(); if (press_hi == 4'b1111) n_all++; end
    chk_int("all4_single_cycle", n_all, 1);
    key_hi = 4'b0000;
    repeat (12) tick();

    // channel 2 staggered by 3 cycles
    key_hi = 4'b1011;
    t0 = -1; t2 = -1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (press_hi[0] && t0 < 0) t0 = k;
      if (press_hi[2] && t2 < 0) t2 = k;
      if (k == 3) key_hi[2] = 1'b1;
    end
    chk_int("stagger_ch0", t0, 9);
    chk_int("stagger_ch2_offset", t2 - t0, 3);
    key_hi = 4'b0000;
    repeat (12) tick();

    // active-low instance: idle through reset, press when driven low
    key_lo = 1'b0;
    find_strobe(4, 1'b0, 20, t);
    chk_int("lo_press_latency", t, 9);
    repeat (3) tick();

    // reset mid-count discards progress
    key_hi[0] = 1'b1;
    repeat (7) tick();
    rstn = 1'b0;
    #1;
    model_reset();
    chk("midrst_state_hi", state_hi, 4'b0000);
    chk("midrst_press_hi", press_hi, 4'b0000);
    chk("midrst_state_lo", {3'b000, state_lo}, 4'b0000);
    check_all();
    tick();
    rstn = 1'b1;
    find_strobe(0, 1'b0, 20, t);
    chk_int("midrst_press_latency", t, 9);

    // randomized toggling on all channels
    for (int k = 0; k < 500; k++) begin
      for (int c = 0; c < 4; c++)
        if ($urandom_range(0, 5) == 0) key_hi[c] = ~key_hi[c];
      if ($urandom_range(0, 5) == 0) key_lo[0] = ~key_lo[0];
      tick();
    end
    key_hi = 4'b0000;
    key_lo = 1'b1;
    repeat (12) tick();

`ifdef DEBOUNCER_MULTI_AUTOREPEAT_EN
    begin
      int rep_q[$];
      int exp_q[$];
      int n_rel, n_press_after;
      bit released;
      exp_q = '{16, 24, 32, 40, 48};
      key_hi[3] = 1'b1;
      find_strobe(3, 1'b0, 20, t);
      chk_int("rep_accept_latency", t, 9);
      for (int k = 1; k <= 50; k++) begin
        tick();
        if (press_hi[3]) rep_q.push_back(k);
      end
      chk_int("rep_count", rep_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++)
        chk_int("rep_offset", (i < rep_q.size()) ? rep_q[i] : -1, exp_q[i]);
      key_hi[3] = 1'b0;
      n_rel = 0; n_press_after = 0; released = 1'b0;
      repeat (30) begin
        tick();
        if (released && press_hi[3]) n_press_after++;
        if (rel_hi[3]) begin n_rel++; released = 1'b1; end
      end
      chk_int("rep_release_once", n_rel, 1);
      chk_int("rep_no_press_after_release", n_press_after, 0);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
